// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Reader end of the fetch interface. Buffers fetch bundles from the frontend
//   (up to FETCH_WIDTH entries per cycle) in a circular queue and hands them to
//   decode one per cycle, in program order, over a valid/ready handshake.
//   A flush (mispredict / exception redirect) discards all queued entries.
//
// Entry layout (ENTRY_W = 70 bits, one fetch_entry_t):
//   [69]    valid     entry holds a real instruction
//   [68]    ex_valid  fetch raised an exception for this entry
//   [67:64] ex_cause  exception cause code
//   [63:32] instr     instruction word
//   [31:0]  addr      instruction address
//
// Ports:
//   clk_i           in   clock
//   rst_i           in   synchronous active-high reset
//   flush_i         in   discard all queued entries
//   fetch_valid_i   in   fetch bundle offered
//   fetch_entry_i   in   FETCH_WIDTH entries, entry i at [i*ENTRY_W +: ENTRY_W]
//   fetch_ready_o   out  queue can take a full bundle
//   decode_entry_o  out  head entry
//   decode_valid_o  out  head entry valid
//   decode_ready_i  in   decode consumes head
//   count_o         out  occupied slots
//
// Configuration:
//   TORTOISE_IFQ_BYPASS_EN  when defined, an empty queue forwards the first
//                           written entry of an accepted bundle straight to
//                           decode in the same cycle.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               fetch_valid_i,
  input  logic [FETCH_WIDTH*70-1:0]          fetch_entry_i,
  output logic                               fetch_ready_o,
  output logic [69:0]                        decode_entry_o,
  output logic                               decode_valid_o,
  input  logic                               decode_ready_i,
  output logic [$clog2(DEPTH):0]             count_o
);

  localparam int ENTRY_W   = 70;
  localparam int VALID_BIT = 69;
  localparam int EXV_BIT   = 68;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  // A full bundle fits while count <= DEPTH - FETCH_WIDTH
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - FETCH_WIDTH);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               fetch_ready_r;

  logic [ENTRY_W-1:0] comp_s [FETCH_WIDTH];
  logic [PTR_W-1:0]   wr_addr_s [FETCH_WIDTH];
  logic [CNT_W-1:0]   n_push_s;
  logic [CNT_W-1:0]   push_n_s;
  logic [CNT_W-1:0]   pop_n_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [PTR_W-1:0]   rd_ptr_next_s;
  logic [PTR_W-1:0]   wr_ptr_next_s;
  logic               push_s;
  logic               pop_s;
  logic               byp_s;

  // Compact valid entries to the low slots; an exception entry ends the bundle
  always_comb begin
    int  idx;
    logic cut;
    idx = 0;
    cut = 1'b0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      comp_s[k] = {ENTRY_W{1'b0}};
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!cut && fetch_entry_i[i*ENTRY_W+VALID_BIT]) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
          if (k == idx) begin
            comp_s[k] = fetch_entry_i[i*ENTRY_W +: ENTRY_W];
          end else begin
            comp_s[k] = comp_s[k];
          end
        end
        idx = idx + 1;
        cut = fetch_entry_i[i*ENTRY_W+EXV_BIT];
      end else begin
        idx = idx;
      end
    end
    n_push_s = CNT_W'(idx);
  end

  // Write addresses for the compacted entries, wrapping modulo DEPTH
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_addr_s[k] = wr_ptr_r + PTR_W'(k);
    end
  end

  // Push is only accepted on registered readiness; reset and flush discard it
  assign push_s = fetch_valid_i && fetch_ready_r && !flush_i && !rst_i;

`ifdef TORTOISE_IFQ_BYPASS_EN
  // Empty queue: the first written entry is presented to decode this cycle.
  // It is still written to storage; if decode takes it, rd_ptr steps over it.
  assign byp_s          = push_s && (count_r == {CNT_W{1'b0}}) && (n_push_s != {CNT_W{1'b0}});
  assign decode_valid_o = (count_r != {CNT_W{1'b0}}) || byp_s;
  assign decode_entry_o = byp_s ? comp_s[0] : mem_r[rd_ptr_r];
`else
  assign byp_s          = 1'b0;
  assign decode_valid_o = (count_r != {CNT_W{1'b0}});
  assign decode_entry_o = mem_r[rd_ptr_r];
`endif

  assign pop_s = decode_valid_o && decode_ready_i && !flush_i && !rst_i;

  // Next-state for occupancy and both pointers
  always_comb begin
    push_n_s = push_s ? n_push_s : {CNT_W{1'b0}};
    pop_n_s  = {{(CNT_W-1){1'b0}}, pop_s};
    if (rst_i || flush_i) begin
      count_next_s  = {CNT_W{1'b0}};
      rd_ptr_next_s = {PTR_W{1'b0}};
      wr_ptr_next_s = {PTR_W{1'b0}};
    end else begin
      count_next_s  = count_r + push_n_s - pop_n_s;
      rd_ptr_next_s = rd_ptr_r + PTR_W'(pop_n_s);
      wr_ptr_next_s = wr_ptr_r + PTR_W'(push_n_s);
    end
  end

  // Control state register; readiness is registered from next occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r       <= {CNT_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      fetch_ready_r <= 1'b1;
    end else begin
      count_r       <= count_next_s;
      rd_ptr_r      <= rd_ptr_next_s;
      wr_ptr_r      <= wr_ptr_next_s;
      fetch_ready_r <= (count_next_s <= READY_LIMIT);
    end
  end

  // Entry storage (no reset; occupancy decides what is meaningful)
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (push_s && (CNT_W'(k) < n_push_s)) begin
        mem_r[wr_addr_s[k]] <= comp_s[k];
      end
    end
  end

  assign fetch_ready_o = fetch_ready_r;
  assign count_o       = count_r;

  instr_fetch_queue_chk #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (FETCH_WIDTH),
    .CNT_W       (CNT_W)
  ) u_chk (
    .clk    (clk_i),
    .rst    (rst_i),
    .count  (count_r),
    .pop    (pop_s),
    .bypass (byp_s)
  );

endmodule

// -----------------------------------------------------------------------------
// instr_fetch_queue_chk
//   Simulation-only invariants of the fetch queue.
// Ports:
//   clk, rst  clock and synchronous reset of the queue
//   count     registered occupancy
//   pop       head consumed this cycle
//   bypass    head is being forwarded from the incoming bundle
// -----------------------------------------------------------------------------
module instr_fetch_queue_chk #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int CNT_W       = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] count,
  input logic             pop,
  input logic             bypass
);

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));

  // Popping an empty queue is only legal when the entry is being bypassed
  a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
    (pop && (count == {CNT_W{1'b0}})) |-> bypass);

  a_params: assert property (@(posedge clk)
    ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= FETCH_WIDTH));

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int W = 70;
`ifdef TORTOISE_IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_i, flush_i, fetch_valid_i, fetch_ready_o;
  logic           decode_valid_o, decode_ready_i;
  logic [2*W-1:0] fetch_entry_i;
  logic [W-1:0]   decode_entry_o;
  logic [3:0]     count_o;

  instr_fetch_queue #(.DEPTH(8), .FETCH_WIDTH(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_entry_i  (fetch_entry_i),
    .fetch_ready_o  (fetch_ready_o),
    .decode_entry_o (decode_entry_o),
    .decode_valid_o (decode_valid_o),
    .decode_ready_i (decode_ready_i),
    .count_o        (count_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] q[$];          // model: queued entries in program order
  bit          order_chk = 1'b0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] na = 32'h0000_4000;

  function automatic logic [W-1:0] ent(input logic v, input logic exv,
                                       input logic [3:0] c, input logic [31:0] a);
    return {v, exv, c, ~a, a};
  endfunction

  function automatic logic [2*W-1:0] bnd(input logic [W-1:0] e0, input logic [W-1:0] e1);
    return {e1, e0};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst_i          = 1'b0;
    flush_i        = 1'b0;
    fetch_valid_i  = 1'b0;
    fetch_entry_i  = '0;
    decode_ready_i = 1'b0;
  endtask

  // One clock: drive, compare against the model, advance the model
  task automatic step(input logic r, input logic f, input logic fv,
                      input logic [2*W-1:0] fe, input logic dr);
    logic [W-1:0] lst[$];
    logic [W-1:0] e, head, popped;
    bit cut, e_ready, acc, byp, e_valid;
    rst_i = r; flush_i = f; fetch_valid_i = fv; fetch_entry_i = fe; decode_ready_i = dr;
    #1;
    cut = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = fe[i*W +: W];
      if (!cut && e[69]) begin
        lst.push_back(e);
        if (e[68]) cut = 1'b1;
      end
    end
    e_ready = (8 - q.size()) >= 2;
    acc     = fv && e_ready && !f && !r;
    byp     = BYP && (q.size() == 0) && acc && (lst.size() > 0);
    e_valid = (q.size() != 0) || byp;
    head    = (q.size() != 0) ? q[0] : ((lst.size() > 0) ? lst[0] : '0);
    chk("fetch_ready", W'(fetch_ready_o), W'(e_ready));
    chk("decode_valid", W'(decode_valid_o), W'(e_valid));
    chk("count", W'(count_o), W'(q.size()));
    if (e_valid) chk("decode_entry", decode_entry_o, head);
    if (r || f) begin
      q.delete();
    end else begin
      if (acc) foreach (lst[j]) q.push_back(lst[j]);
      if (e_valid && dr) begin
        popped = q.pop_front();
        if (order_chk) chk("order_increasing", W'(popped[31:0] > last_addr), W'(1));
        last_addr = popped[31:0];
      end
    end
    @(negedge clk);
    idle();
    #1;
  endtask

  task automatic pushb(input logic [W-1:0] e0, input logic [W-1:0] e1, input logic dr);
    step(1'b0, 1'b0, 1'b1, bnd(e0, e1), dr);
  endtask

  task automatic wait1(input logic dr);
    step(1'b0, 1'b0, 1'b0, '0, dr);
  endtask

  task automatic pushn(input logic dr);
    pushb(ent(1'b1, 1'b0, 4'h0, na), ent(1'b1, 1'b0, 4'h0, na + 32'd4), dr);
    na = na + 32'd8;
  endtask

  initial begin
    logic [2*W-1:0] fe;
    idle();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    q.delete();
    idle();
    #1;
    chk("reset_count", W'(count_o), W'(0));
    chk("reset_ready", W'(fetch_ready_o), W'(1));
    chk("reset_valid", W'(decode_valid_o), W'(0));

    // 1: two-entry bundle drained immediately
    pushb(ent(1'b1, 1'b0, 4'h0, 32'h8000_0000), ent(1'b1, 1'b0, 4'h0, 32'h8000_0004), 1'b1);
`ifndef TORTOISE_IFQ_BYPASS_EN
    chk("t1_count2", W'(count_o), W'(2));
    chk("t1_head0", W'(decode_entry_o[31:0]), W'(32'h8000_0000));
`endif
    wait1(1'b1);
`ifndef TORTOISE_IFQ_BYPASS_EN
    chk("t1_count1", W'(count_o), W'(1));
    chk("t1_head1", W'(decode_entry_o[31:0]), W'(32'h8000_0004));
`endif
    wait1(1'b1);
    chk("t1_count0", W'(count_o), W'(0));

    // 2: fill to full, reject a fifth bundle, drain in order
    for (int k = 0; k < 4; k++)
      pushb(ent(1'b1, 1'b0, 4'h0, 32'h1000 + 32'(8*k)),
            ent(1'b1, 1'b0, 4'h0, 32'h1004 + 32'(8*k)), 1'b0);
    chk("t2_full_count", W'(count_o), W'(8));
    chk("t2_full_ready", W'(fetch_ready_o), W'(0));
    pushb(ent(1'b1, 1'b0, 4'h0, 32'h2000), ent(1'b1, 1'b0, 4'h0, 32'h2004), 1'b0);
    chk("t2_ignored", W'(count_o), W'(8));
    for (int k = 0; k < 8; k++) begin
      chk("t2_drain_addr", W'(decode_entry_o[31:0]), W'(32'h1000 + 32'(4*k)));
      wait1(1'b1);
      if (k == 0) chk("t2_ready_at7", W'(fetch_ready_o), W'(0));
      if (k == 1) chk("t2_ready_at6", W'(fetch_ready_o), W'(1));
    end

    // 3: only the valid entry is stored
    pushb(ent(1'b0, 1'b0, 4'h0, 32'h100), ent(1'b1, 1'b0, 4'h0, 32'h104), 1'b0);
    chk("t3_count", W'(count_o), W'(1));
    chk("t3_head", W'(decode_entry_o[31:0]), W'(32'h104));
    wait1(1'b1);

    // 4: exception entry cuts the rest of the bundle
    pushb(ent(1'b1, 1'b1, 4'hC, 32'h200), ent(1'b1, 1'b0, 4'h0, 32'h204), 1'b0);
    chk("t4_count", W'(count_o), W'(1));
    chk("t4_entry", decode_entry_o, ent(1'b1, 1'b1, 4'hC, 32'h200));
    wait1(1'b1);
    chk("t4_empty", W'(count_o), W'(0));

    // 5: wrap-around at rd_ptr=6, then flush with push+pop
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) pushn(1'b0);
    repeat (6) wait1(1'b1);
    repeat (3) pushn(1'b0);
    chk("t5_count6", W'(count_o), W'(6));
    order_chk = 1'b1;
    repeat (10) pushn(1'b1);
    order_chk = 1'b0;
    step(1'b0, 1'b1, 1'b1, bnd(ent(1'b1, 1'b0, 4'h0, na), ent(1'b1, 1'b0, 4'h0, na + 32'd4)), 1'b1);
    chk("t5_flush_count", W'(count_o), W'(0));
    chk("t5_flush_valid", W'(decode_valid_o), W'(0));

    // 6: push into empty queue with decode ready
    fe = bnd(ent(1'b1, 1'b0, 4'h0, 32'h300), ent(1'b1, 1'b0, 4'h0, 32'h304));
    fetch_valid_i = 1'b1; fetch_entry_i = fe; decode_ready_i = 1'b1;
    #1;
`ifdef TORTOISE_IFQ_BYPASS_EN
    chk("t6_byp_valid", W'(decode_valid_o), W'(1));
    chk("t6_byp_head", W'(decode_entry_o[31:0]), W'(32'h300));
`else
    chk("t6_nobyp_valid", W'(decode_valid_o), W'(0));
`endif
    step(1'b0, 1'b0, 1'b1, fe, 1'b1);
`ifdef TORTOISE_IFQ_BYPASS_EN
    chk("t6_count", W'(count_o), W'(1));
    chk("t6_next_head", W'(decode_entry_o[31:0]), W'(32'h304));
`else
    chk("t6_count", W'(count_o), W'(2));
    chk("t6_next_head", W'(decode_entry_o[31:0]), W'(32'h300));
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        fe[i*W +: W] = ent($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                           4'($urandom_range(0, 15)), na);
        na = na + 32'd4;
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1, fe, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
